// File: rtl/booth_multiplier.sv
// Sequential signed WIDTH x WIDTH -> 2*WIDTH multiplier, radix-2 Booth, one step per clock.
// The hi/lo result registers are loaded only on the final Booth step and hold until the next result or reset.
module booth_multiplier #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    // ACC and M carry one extra bit so that -M is representable for a = -2^(WIDTH-1)
    logic [WIDTH:0]     r_acc;
    logic [WIDTH:0]     r_m;
    logic [WIDTH-1:0]   r_q;
    logic               r_q1;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_acc_sh;
    logic [WIDTH-1:0]   w_q_sh;
    logic               w_last;

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        w_sum = r_acc;
        case ({r_q[0], r_q1})
            2'b01:   w_sum = r_acc + r_m;
            2'b10:   w_sum = r_acc - r_m;
            default: w_sum = r_acc;
        endcase
    end

    // Arithmetic right shift of the concatenation {ACC, Q, Q_1}
    assign w_acc_sh = {w_sum[WIDTH], w_sum[WIDTH:1]};
    assign w_q_sh   = {w_sum[0], r_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
            r_m   <= '0;
            r_q   <= '0;
            r_q1  <= 1'b0;
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc <= '0;
                        r_m   <= {a[WIDTH-1], a};
                        r_q   <= b;
                        r_q1  <= 1'b0;
                        r_cnt <= '0;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_sh;
                    r_q   <= w_q_sh;
                    r_q1  <= r_q[0];
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_hi <= w_acc_sh[WIDTH-1:0];
                        r_lo <= w_q_sh;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule

// File: tb/tb_booth_multiplier.sv
// Testbench for booth_multiplier: vector table, randomized operands against a signed-product model,
// and hand-written sequences for start-while-busy, held start and reset mid-operation.
module tb_booth_multiplier;

    localparam int WIDTH   = 32;
    localparam int LATENCY = WIDTH + 1;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    int checks;
    int failures;

    booth_multiplier #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] va;
        logic [WIDTH-1:0] vb;
        logic [WIDTH-1:0] ehi;
        logic [WIDTH-1:0] elo;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_product(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb);
        longint pa;
        longint pb;
        pa = longint'($signed(ma));
        pb = longint'($signed(mb));
        return 64'(pa * pb);
    endfunction

    // Launches one multiply at the next falling edge and waits for done (bounded).
    // Returns the result, the number of falling edges from the start edge to done,
    // and whether hi/lo stayed put and busy stayed high for the whole run.
    task automatic do_mult(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                           output logic [WIDTH-1:0] rhi, output logic [WIDTH-1:0] rlo,
                           output int lat, output bit run_ok);
        logic [WIDTH-1:0] hold_hi;
        logic [WIDTH-1:0] hold_lo;
        @(negedge clk);
        hold_hi = hi;
        hold_lo = lo;
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        run_ok = 1'b1;
        lat    = 0;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 100) begin
            if (!busy || hi !== hold_hi || lo !== hold_lo) run_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (busy) run_ok = 1'b0;
        rhi = hi;
        rlo = lo;
    endtask

    logic [WIDTH-1:0] rhi;
    logic [WIDTH-1:0] rlo;
    logic [63:0]      exp_p;
    int               lat;
    bit               run_ok;
    bit               flag;
    int               done_cycles[$];

    initial begin
        checks   = 0;
        failures = 0;

        vecs[0] = '{32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F};
        vecs[1] = '{32'hFFFF_FFF9, 32'h0000_0006, 32'hFFFF_FFFF, 32'hFFFF_FFD6};
        vecs[2] = '{32'h0000_0006, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFD6};
        vecs[3] = '{32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[4] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001};
        vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[6] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000, 32'h8000_0000};

        reset = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("reset_hi",   64'(hi),   64'h0);
        check("reset_lo",   64'(lo),   64'h0);
        check("reset_busy", 64'(busy), 64'h0);
        check("reset_done", 64'(done), 64'h0);
        reset = 1'b1;

        // Table-driven vectors, issued back to back
        for (int i = 0; i < 7; i++) begin
            do_mult(vecs[i].va, vecs[i].vb, rhi, rlo, lat, run_ok);
            $display("vec %0d: a=0x%h b=0x%h -> hi=0x%h lo=0x%h lat=%0d", i, vecs[i].va, vecs[i].vb, rhi, rlo, lat);
            check($sformatf("vec%0d_hi", i), 64'(rhi), 64'(vecs[i].ehi));
            check($sformatf("vec%0d_lo", i), 64'(rlo), 64'(vecs[i].elo));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(LATENCY));
            check($sformatf("vec%0d_run_hold", i), 64'(run_ok), 64'h1);
        end

        // Randomized operands against the signed-product model
        for (int i = 0; i < 24; i++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) ra = (ra[0]) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            if ($urandom_range(0, 3) == 0) rb = (rb[0]) ? 32'h8000_0000 : 32'hFFFF_FFFF;
            exp_p = model_product(ra, rb);
            do_mult(ra, rb, rhi, rlo, lat, run_ok);
            $display("rnd %0d: a=0x%h b=0x%h -> hi=0x%h lo=0x%h lat=%0d", i, ra, rb, rhi, rlo, lat);
            check($sformatf("rnd%0d_product", i), {rhi, rlo}, exp_p);
            check($sformatf("rnd%0d_latency", i), 64'(lat), 64'(LATENCY));
            check($sformatf("rnd%0d_run_hold", i), 64'(run_ok), 64'h1);
        end

        // Start while busy is ignored; later a/b changes have no effect
        @(negedge clk);
        a = 32'd4; b = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        repeat (9) begin
            @(negedge clk);
            lat++;
        end
        a = 32'd9; b = 32'd9; start = 1'b1;
        @(negedge clk);
        lat++;
        start = 1'b0; a = 32'd7; b = 32'd3;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        $display("busy-ignore: hi=0x%h lo=0x%h lat=%0d", hi, lo, lat);
        check("ignore_hi", 64'(hi), 64'h0);
        check("ignore_lo", 64'(lo), 64'h14);
        check("ignore_latency", 64'(lat), 64'(LATENCY));
        flag = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (hi !== 32'h0 || lo !== 32'h14 || busy || done) flag = 1'b0;
        end
        $display("idle hold over 40 cycles: ok=%0d", flag);
        check("idle_hold", 64'(flag), 64'h1);

        // Start held high: one launch per IDLE entry
        a = 32'd3; b = 32'd7; start = 1'b1;
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk);
            if (done) done_cycles.push_back(c);
        end
        start = 1'b0;
        $display("held start: %0d done pulses", done_cycles.size());
        check("held_pulse_count", 64'(done_cycles.size()), 64'd3);
        if (done_cycles.size() == 3) begin
            check("held_first_latency", 64'(done_cycles[0]), 64'(LATENCY));
            check("held_interval_1", 64'(done_cycles[1] - done_cycles[0]), 64'(WIDTH + 2));
            check("held_interval_2", 64'(done_cycles[2] - done_cycles[1]), 64'(WIDTH + 2));
        end
        lat = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("held_product_lo", 64'(lo), 64'd21);
        check("held_product_hi", 64'(hi), 64'd0);

        // Reset mid-operation
        @(negedge clk);
        a = 32'd100; b = 32'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        $display("mid-run reset: hi=0x%h lo=0x%h busy=%0d done=%0d", hi, lo, busy, done);
        check("midreset_hi",   64'(hi),   64'h0);
        check("midreset_lo",   64'(lo),   64'h0);
        check("midreset_busy", 64'(busy), 64'h0);
        check("midreset_done", 64'(done), 64'h0);
        @(negedge clk);
        reset = 1'b1;
        flag = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done || busy || hi !== 32'h0 || lo !== 32'h0) flag = 1'b0;
        end
        check("midreset_no_done", 64'(flag), 64'h1);
        do_mult(32'd2, 32'd2, rhi, rlo, lat, run_ok);
        $display("after reset: a=2 b=2 -> hi=0x%h lo=0x%h lat=%0d", rhi, rlo, lat);
        check("post_reset_lo", 64'(rlo), 64'd4);
        check("post_reset_hi", 64'(rhi), 64'd0);
        check("post_reset_latency", 64'(lat), 64'(LATENCY));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
